bank_router: RTL and testbench
==============================

Name: bank_router

Overview:
- Parametrised successor to the DE0 top-level memory router; sits between avrcpu and all data-side memories.
- Decodes CPU data accesses:
  - Outside the window: internal SRAM, zero wait.
  - Inside the high window: one of NUM_TARGETS banked targets, selected by a bank register at an I/O port.
- Window targets use a req/ack handshake with CPU stall, timeout and a sticky error flag, so slow targets (SDRAM, SD buffers, graphics RAM) can be banked in.

Parameters:
- WIN_BASE, 16'hF000, first address of banked window; window is 2^WIN_BITS bytes.
- WIN_BITS, 12, window offset width.
- SUB_BITS, 1, low bank-register bits forwarded to the target as sub-page.
- NUM_TARGETS, 4, target slots; slot 0 is reserved as unmapped.
- BANK_PORT, 16'h0020, address of bank register; status register at BANK_PORT+1.
- TIMEOUT, 255, max cycles waiting for ack, 8-bit max.

Ports:
- clock  in  1  system clock, all logic on posedge
- reset  in  1  asynchronous, active-high
- cpu_address  in  16  CPU data address
- cpu_data_o  in  8  CPU write data
- cpu_wren  in  1  CPU write strobe
- cpu_rden  in  1  CPU read strobe
- cpu_data_i  out  8  read data to CPU
- cpu_stall  out  1  hold CPU; access not complete
- sram_address  out  16  equals cpu_address
- sram_data  out  8  equals cpu_data_o
- sram_wren  out  1  SRAM write enable
- sram_q  in  8  SRAM read data
- win_address  out  SUB_BITS+WIN_BITS  {sub-page, offset}
- win_data  out  8  write data to target
- win_sel  out  NUM_TARGETS  one-hot target select
- win_req  out  1  request strobe, level, held until ack/timeout
- win_we  out  1  1 = write request
- win_q  in  8*NUM_TARGETS  per-target read data, slot i at [8i+7:8i]
- win_ack  in  NUM_TARGETS  per-target acknowledge
- bank  out  8  current bank register

Behaviour:
- Reset: bank=0, err=0, FSM=IDLE. Outputs: win_req=0, win_sel=0, win_we=0, cpu_stall=0, latched data=8'hFF.
- Target index t = bank >> SUB_BITS; mapped iff 1 <= t < NUM_TARGETS.
- A window hit requires (cpu_address & ~(2^WIN_BITS-1)) == WIN_BASE. Outside a window hit, accesses go to SRAM unless the address is a port.
- SRAM path is combinational:
  - sram_wren = cpu_wren & ~hit & ~port.
  - cpu_data_i = sram_q.
  - No stall.
- Ports:
  - Read BANK_PORT returns bank.
  - Read BANK_PORT+1 returns {7'b0, err}.
  - Port writes register on posedge: BANK_PORT loads bank; BANK_PORT+1 with bit0=1 clears err.
  - Ports never reach SRAM.
- Unmapped window:
  - Reads return 8'hFF.
  - Writes are dropped.
  - No stall, no req.
- FSM for mapped window access with cpu_rden|cpu_wren:
  - IDLE->REQ.
  - REQ:
    - win_req=1, win_sel=1<<t, win_we=cpu_wren; address and data are driven from the CPU, which holds them while stalled.
    - Counter increments each cycle.
    - win_ack[t]=1: latch win_q[t], go to DONE.
    - Counter == TIMEOUT without ack: latch 8'hFF, set err, go to DONE.
  - DONE:
    - win_req=0, cpu_data_i = latched data, cpu_stall=0.
    - Next state is IDLE.
  - cpu_stall = hit & mapped & (rden|wren) & (state != DONE). It is asserted combinationally in IDLE.
  - Minimum latency: req in cycle 1, ack in cycle 1, data in cycle 2, i.e. 2 cycles.
- Acks on non-selected targets and acks outside REQ are ignored.
- A bank write during REQ cannot occur (CPU stalled). If it is forced, the change takes effect on the next access only; win_sel stays latched at REQ entry.
- Err set by timeout and cleared by port write in the same cycle: set wins.
- Reset mid-REQ: win_req drops immediately (async), FSM=IDLE, no err.
- Back-to-back window accesses: each passes through IDLE; no pipelining.

Decomposition:
- Shared package bank_router_pkg: FSM state encoding (IDLE, REQ, DONE), status bit index ERR_BIT=0, unmapped read value 8'hFF.
- One natural sub-module, win_handshake: FSM, timeout counter, data latch. The top keeps decode, ports and muxing.

Test Plan:
- Reset, then read 16'h0100 with sram_q=8'h5A -> cpu_data_i=8'h5A, cpu_stall=0, sram_wren=0, bank=0.
- Write 8'h02 to 16'h0020, then read 16'h0020 -> 8'h02.
  - Read 16'hF123 with win_ack[1] after 3 cycles and win_q[1]=8'hC3 -> stall for 4 cycles, win_address=13'h0123, win_sel=4'b0010, data 8'hC3 in DONE.
- bank=8'h03, write 8'h77 to 16'hF800 -> win_we=1, win_address=13'h1800, win_sel=4'b0010, sram_wren=0 throughout.
- bank=0, read 16'hF000 -> 8'hFF, no stall, win_req=0. bank=8'h08 (t=4), write -> dropped.
- Mapped read, no ack -> stall TIMEOUT+1 cycles, data 8'hFF.
  - Read 16'h0021 then returns 8'h01; write 8'h01 to 16'h0021 clears it to 8'h00.
- Assert reset during REQ -> win_req=0 same cycle, bank=0, cpu_stall=0 after release.

Source files
------------

// File: rtl/bank_router_pkg.sv
// Shared definitions for the banked data-memory router: handshake FSM
// encoding, status register layout and the value returned for reads that
// no target answers.
package bank_router_pkg;

  // Window handshake states. Every window access passes IDLE -> REQ -> DONE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } hs_state_t;

  // Bit position of the sticky error flag inside the status register.
  localparam int ERR_BIT = 0;

  // Read value for unmapped slots and for timed-out requests.
  localparam logic [7:0] UNMAPPED_VAL = 8'hFF;

  // Build the status register byte from the sticky error flag.
  function automatic logic [7:0] status_byte(input logic err);
    logic [7:0] s;
    s = 8'h00;
    s[ERR_BIT] = err;
    return s;
  endfunction

endpackage

// File: rtl/bank_router_win_handshake.sv
// Request/acknowledge engine for the banked window. Holds the target select
// latched at request start, counts cycles spent waiting for the acknowledge,
// and captures the returned byte (or the unmapped value on timeout).
module win_handshake
  import bank_router_pkg::*;
#(
  parameter int NUM_TARGETS = 4,
  parameter int TIMEOUT     = 255
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     wr,
  input  logic [NUM_TARGETS-1:0]   sel,
  input  logic [8*NUM_TARGETS-1:0] win_q,
  input  logic [NUM_TARGETS-1:0]   win_ack,
  output hs_state_t                state,
  output logic                     win_req,
  output logic [NUM_TARGETS-1:0]   win_sel,
  output logic                     win_we,
  output logic [7:0]               rdata,
  output logic                     timeout
);

  localparam logic [7:0] TIMEOUT_V = 8'(TIMEOUT);

  hs_state_t              state_r;
  logic                   req_r;
  logic [NUM_TARGETS-1:0] sel_r;
  logic                   we_r;
  logic [7:0]             cnt_r;
  logic [7:0]             data_r;

  logic                   ack_s;
  logic [7:0]             q_s;
  logic [7:0]             cnt_next_s;

  // Acknowledge and read data of the latched target only; other acks are ignored.
  always_comb begin
    q_s = 8'h00;
    for (int i = 0; i < NUM_TARGETS; i++) begin
      if (sel_r[i]) begin
        q_s = q_s | win_q[8*i +: 8];
      end else begin
        q_s = q_s;
      end
    end
    if (state_r == ST_REQ) begin
      ack_s = |(win_ack & sel_r);
    end else begin
      ack_s = 1'b0;
    end
  end

  // cnt_next_s is the number of REQ cycles including the current one.
  assign cnt_next_s = cnt_r + 8'd1;
  assign timeout    = (state_r == ST_REQ) && !ack_s && (cnt_next_s == TIMEOUT_V);

  // Handshake FSM with registered request strobe, select, direction and data latch.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      req_r   <= 1'b0;
      sel_r   <= '0;
      we_r    <= 1'b0;
      cnt_r   <= 8'd0;
      data_r  <= UNMAPPED_VAL;
    end else begin
      case (state_r)
        ST_IDLE: begin
          cnt_r <= 8'd0;
          if (start) begin
            state_r <= ST_REQ;
            req_r   <= 1'b1;
            sel_r   <= sel;
            we_r    <= wr;
          end
        end
        ST_REQ: begin
          cnt_r <= cnt_next_s;
          if (ack_s) begin
            data_r  <= q_s;
            state_r <= ST_DONE;
            req_r   <= 1'b0;
            sel_r   <= '0;
            we_r    <= 1'b0;
          end else if (timeout) begin
            data_r  <= UNMAPPED_VAL;
            state_r <= ST_DONE;
            req_r   <= 1'b0;
            sel_r   <= '0;
            we_r    <= 1'b0;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
          req_r   <= 1'b0;
          sel_r   <= '0;
          we_r    <= 1'b0;
        end
      endcase
    end
  end

  assign state   = state_r;
  assign win_req = req_r;
  assign win_sel = sel_r;
  assign win_we  = we_r;
  assign rdata   = data_r;

endmodule

// File: rtl/bank_router.sv
// Data-side memory router for the AVR core. Addresses outside the banked
// window go to internal SRAM with no wait states; the window is routed to
// one of several slow targets chosen by an I/O bank register, with CPU stall,
// timeout and a sticky error flag in a status register.
module bank_router
  import bank_router_pkg::*;
#(
  parameter logic [15:0] WIN_BASE    = 16'hF000,
  parameter int          WIN_BITS    = 12,
  parameter int          SUB_BITS    = 1,
  parameter int          NUM_TARGETS = 4,
  parameter logic [15:0] BANK_PORT   = 16'h0020,
  parameter int          TIMEOUT     = 255
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [15:0]                  cpu_address,
  input  logic [7:0]                   cpu_data_o,
  input  logic                         cpu_wren,
  input  logic                         cpu_rden,
  output logic [7:0]                   cpu_data_i,
  output logic                         cpu_stall,
  output logic [15:0]                  sram_address,
  output logic [7:0]                   sram_data,
  output logic                         sram_wren,
  input  logic [7:0]                   sram_q,
  output logic [SUB_BITS+WIN_BITS-1:0] win_address,
  output logic [7:0]                   win_data,
  output logic [NUM_TARGETS-1:0]       win_sel,
  output logic                         win_req,
  output logic                         win_we,
  input  logic [8*NUM_TARGETS-1:0]     win_q,
  input  logic [NUM_TARGETS-1:0]       win_ack,
  output logic [7:0]                   bank
);

  localparam logic [15:0] WIN_MASK    = 16'((32'd1 << WIN_BITS) - 32'd1);
  localparam logic [15:0] STATUS_PORT = BANK_PORT + 16'd1;

  logic [7:0]             bank_r;
  logic                   err_r;

  logic                   hit_s;
  logic                   bank_port_s;
  logic                   status_port_s;
  logic                   port_s;
  logic [7:0]             t_s;
  logic                   mapped_s;
  logic                   access_s;
  logic                   win_access_s;
  logic [NUM_TARGETS-1:0] sel_s;

  hs_state_t              hs_state_s;
  logic [7:0]             hs_data_s;
  logic                   timeout_s;

  // Address decode and target mapping from the current bank register.
  always_comb begin
    hit_s         = ((cpu_address & ~WIN_MASK) == WIN_BASE);
    bank_port_s   = (cpu_address == BANK_PORT);
    status_port_s = (cpu_address == STATUS_PORT);
    port_s        = bank_port_s | status_port_s;
    t_s           = bank_r >> SUB_BITS;
    mapped_s      = (int'(t_s) >= 1) && (int'(t_s) < NUM_TARGETS);
    access_s      = cpu_rden | cpu_wren;
    win_access_s  = hit_s & mapped_s & access_s;
    if (mapped_s) begin
      sel_s = NUM_TARGETS'(1) << t_s;
    end else begin
      sel_s = '0;
    end
  end

  win_handshake #(
    .NUM_TARGETS (NUM_TARGETS),
    .TIMEOUT     (TIMEOUT)
  ) u_hs (
    .clock   (clock),
    .reset   (reset),
    .start   (win_access_s),
    .wr      (cpu_wren),
    .sel     (sel_s),
    .win_q   (win_q),
    .win_ack (win_ack),
    .state   (hs_state_s),
    .win_req (win_req),
    .win_sel (win_sel),
    .win_we  (win_we),
    .rdata   (hs_data_s),
    .timeout (timeout_s)
  );

  // Bank register loads from a CPU write to the bank port; takes effect on the next access.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bank_r <= 8'h00;
    end else if (cpu_wren && bank_port_s) begin
      bank_r <= cpu_data_o;
    end else begin
      bank_r <= bank_r;
    end
  end

  // Sticky error flag: set by a timeout, cleared by writing 1 to its status bit; set has priority.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_r <= 1'b0;
    end else if (timeout_s) begin
      err_r <= 1'b1;
    end else if (cpu_wren && status_port_s && cpu_data_o[ERR_BIT]) begin
      err_r <= 1'b0;
    end else begin
      err_r <= err_r;
    end
  end

  // Read data mux: ports first, then window (latched or unmapped), then SRAM.
  always_comb begin
    if (bank_port_s) begin
      cpu_data_i = bank_r;
    end else if (status_port_s) begin
      cpu_data_i = status_byte(err_r);
    end else if (hit_s) begin
      if (mapped_s) begin
        cpu_data_i = hs_data_s;
      end else begin
        cpu_data_i = UNMAPPED_VAL;
      end
    end else begin
      cpu_data_i = sram_q;
    end
  end

  // The CPU is held from the first cycle of a mapped window access until DONE.
  assign cpu_stall    = win_access_s && (hs_state_s != ST_DONE);

  assign sram_address = cpu_address;
  assign sram_data    = cpu_data_o;
  assign sram_wren    = cpu_wren & ~hit_s & ~port_s;

  assign win_address  = {bank_r[SUB_BITS-1:0], cpu_address[WIN_BITS-1:0]};
  assign win_data     = cpu_data_o;
  assign bank         = bank_r;

endmodule

// File: tb/tb_bank_router.sv
// Scoreboard bench for bank_router: read accesses push their expected byte,
// a monitor pops and compares whenever a read completes (rden with no stall).
module tb_bank_router;

  localparam int TIMEOUT = 255;

  logic        clock;
  logic        reset;
  logic [15:0] cpu_address;
  logic [7:0]  cpu_data_o;
  logic        cpu_wren;
  logic        cpu_rden;
  logic [7:0]  cpu_data_i;
  logic        cpu_stall;
  logic [15:0] sram_address;
  logic [7:0]  sram_data;
  logic        sram_wren;
  logic [7:0]  sram_q;
  logic [12:0] win_address;
  logic [7:0]  win_data;
  logic [3:0]  win_sel;
  logic        win_req;
  logic        win_we;
  logic [31:0] win_q;
  logic [3:0]  win_ack;
  logic [7:0]  bank;

  bank_router dut (
    .clock        (clock),
    .reset        (reset),
    .cpu_address  (cpu_address),
    .cpu_data_o   (cpu_data_o),
    .cpu_wren     (cpu_wren),
    .cpu_rden     (cpu_rden),
    .cpu_data_i   (cpu_data_i),
    .cpu_stall    (cpu_stall),
    .sram_address (sram_address),
    .sram_data    (sram_data),
    .sram_wren    (sram_wren),
    .sram_q       (sram_q),
    .win_address  (win_address),
    .win_data     (win_data),
    .win_sel      (win_sel),
    .win_req      (win_req),
    .win_we       (win_we),
    .win_q        (win_q),
    .win_ack      (win_ack),
    .bank         (bank)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  val;
  } exp_t;

  exp_t sbq[$];
  int   tests = 0;
  int   fails = 0;

  // Target responder settings
  logic [3:0] ack_mask;
  int         ack_delay;
  int         req_cyc;

  // Per-access observations
  int          stall_n;
  logic        seen_req;
  logic        seen_wren;
  logic [12:0] cap_addr;
  logic [3:0]  cap_sel;
  logic        cap_we;
  logic [7:0]  cap_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Responder: acks with ack_mask on the ack_delay-th cycle of a request.
  initial begin
    win_ack = 4'b0000;
    req_cyc = 0;
    forever begin
      @(posedge clock);
      #1;
      if (win_req) req_cyc++;
      else req_cyc = 0;
      win_ack = (win_req && req_cyc == ack_delay) ? ack_mask : 4'b0000;
    end
  end

  // Monitor: a read completes when rden is high and the CPU is not stalled.
  always @(negedge clock) begin
    if (!reset && cpu_rden && !cpu_stall) begin
      tests++;
      if (sbq.size() == 0) begin
        fails++;
        $display("FAIL unexpected_read addr=%h actual=%h required=none", cpu_address, cpu_data_i);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        if (cpu_data_i !== e.val) begin
          fails++;
          $display("FAIL read_%h actual=%h required=%h", e.addr, cpu_data_i, e.val);
        end
      end
    end
  end

  // One CPU access; reads push their expected byte into the scoreboard.
  task automatic access(input logic [15:0] addr, input logic [7:0] data,
                        input logic is_wr, input logic [7:0] exp_rd);
    bit done;
    exp_t e;
    @(posedge clock);
    #1;
    cpu_address = addr;
    cpu_data_o  = data;
    cpu_wren    = is_wr;
    cpu_rden    = !is_wr;
    if (!is_wr) begin
      e.addr = addr;
      e.val  = exp_rd;
      sbq.push_back(e);
    end
    stall_n   = 0;
    seen_req  = 1'b0;
    seen_wren = 1'b0;
    done      = 1'b0;
    while (!done) begin
      @(negedge clock);
      seen_req  = seen_req | win_req;
      seen_wren = seen_wren | sram_wren;
      if (win_req) begin
        cap_addr = win_address;
        cap_sel  = win_sel;
        cap_we   = win_we;
        cap_data = win_data;
      end
      if (!cpu_stall) begin
        done = 1'b1;
      end else begin
        stall_n++;
        if (stall_n > 600) begin
          tests++;
          fails++;
          $display("FAIL stall_bound addr=%h actual=%0d required<=600", addr, stall_n);
          done = 1'b1;
        end
      end
    end
    @(posedge clock);
    #1;
    cpu_wren = 1'b0;
    cpu_rden = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    cpu_address = 16'h0000;
    cpu_data_o  = 8'h00;
    cpu_wren    = 1'b0;
    cpu_rden    = 1'b0;
    sram_q      = 8'h5A;
    win_q       = {8'h44, 8'h33, 8'hC3, 8'h11};
    ack_mask    = 4'b0000;
    ack_delay   = 1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clock);
    check("rst_stall", {31'd0, cpu_stall}, 32'd0);
    check("rst_req", {31'd0, win_req}, 32'd0);
    check("rst_sel", {28'd0, win_sel}, 32'd0);
    check("rst_we", {31'd0, win_we}, 32'd0);
    check("rst_bank", {24'd0, bank}, 32'd0);

    // SRAM read and write
    access(16'h0100, 8'h00, 1'b0, 8'h5A);
    check("sram_rd_stall", stall_n, 0);
    check("sram_rd_wren", {31'd0, seen_wren}, 32'd0);
    access(16'h0100, 8'h3C, 1'b1, 8'h00);
    check("sram_wr_wren", {31'd0, seen_wren}, 32'd1);

    // Bank port write/read
    access(16'h0020, 8'h02, 1'b1, 8'h00);
    check("port_wr_no_sram", {31'd0, seen_wren}, 32'd0);
    access(16'h0020, 8'h00, 1'b0, 8'h02);

    // Mapped read, ack on third request cycle
    ack_mask  = 4'b0010;
    ack_delay = 3;
    access(16'hF123, 8'h00, 1'b0, 8'hC3);
    check("win_rd_stall", stall_n, 4);
    check("win_rd_addr", {19'd0, cap_addr}, 32'h0123);
    check("win_rd_sel", {28'd0, cap_sel}, 32'b0010);
    check("win_rd_we", {31'd0, cap_we}, 32'd0);

    // Mapped write with sub-page, minimum latency
    access(16'h0020, 8'h03, 1'b1, 8'h00);
    ack_delay = 1;
    access(16'hF800, 8'h77, 1'b1, 8'h00);
    check("win_wr_stall", stall_n, 2);
    check("win_wr_we", {31'd0, cap_we}, 32'd1);
    check("win_wr_addr", {19'd0, cap_addr}, 32'h1800);
    check("win_wr_sel", {28'd0, cap_sel}, 32'b0010);
    check("win_wr_data", {24'd0, cap_data}, 32'h77);
    check("win_wr_no_sram", {31'd0, seen_wren}, 32'd0);

    // Unmapped slot 0 read, slot 4 write
    access(16'h0020, 8'h00, 1'b1, 8'h00);
    access(16'hF000, 8'h00, 1'b0, 8'hFF);
    check("unmap_rd_stall", stall_n, 0);
    check("unmap_rd_req", {31'd0, seen_req}, 32'd0);
    access(16'h0020, 8'h08, 1'b1, 8'h00);
    access(16'hF000, 8'h55, 1'b1, 8'h00);
    check("unmap_wr_stall", stall_n, 0);
    check("unmap_wr_req", {31'd0, seen_req}, 32'd0);
    check("unmap_wr_sram", {31'd0, seen_wren}, 32'd0);

    // Timeout with acks only on non-selected targets
    access(16'h0020, 8'h02, 1'b1, 8'h00);
    ack_mask  = 4'b1101;
    ack_delay = 1;
    access(16'hF010, 8'h00, 1'b0, 8'hFF);
    check("tmo_stall", stall_n, TIMEOUT + 1);
    access(16'h0021, 8'h00, 1'b0, 8'h01);
    access(16'h0021, 8'h01, 1'b1, 8'h00);
    access(16'h0021, 8'h00, 1'b0, 8'h00);

    // Reset during REQ
    ack_mask = 4'b0000;
    @(posedge clock);
    #1;
    cpu_address = 16'hF000;
    cpu_rden    = 1'b1;
    repeat (3) @(negedge clock);
    check("mid_req_before", {31'd0, win_req}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("mid_req_drop", {31'd0, win_req}, 32'd0);
    cpu_rden = 1'b0;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("post_rst_stall", {31'd0, cpu_stall}, 32'd0);
    check("post_rst_bank", {24'd0, bank}, 32'd0);
    check("post_rst_sel", {28'd0, win_sel}, 32'd0);
    access(16'h0021, 8'h00, 1'b0, 8'h00);

    repeat (2) @(posedge clock);
    check("sb_empty", sbq.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
